// File: rtl/ex_hazard_ctrl_pkg.sv
// ex_hazard_ctrl_pkg
//   Types and constants shared by the EX-stage hazard controller and its
//   load-use comparator.
//   hz_state_t : controller FSM state, 2-bit encoding (IDLE = 0).
//   REG_IDX_W  : width of a register index (16 architectural registers).
package ex_hazard_ctrl_pkg;

   localparam int REG_IDX_W = 4;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      CTRL_WAIT = 2'd1,
      RET_WAIT  = 2'd2,
      FLUSH     = 2'd3
   } hz_state_t;

endpackage

// File: rtl/ex_hazard_ctrl_ld_use_detect.sv
// ld_use_detect
//   Purely combinational load-use comparator. Flags the case where the
//   instruction in ID reads the register that the load currently in EX
//   will write. R0 is hard-wired, so it never creates a hazard.
//   Inputs : id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_mem_to_reg, ex_reg_rd
//   Output : hazard
module ld_use_detect
   import ex_hazard_ctrl_pkg::*;
(
   input  logic [REG_IDX_W-1:0] id_rs1,
   input  logic [REG_IDX_W-1:0] id_rs2,
   input  logic                 id_rs1_used,
   input  logic                 id_rs2_used,
   input  logic                 ex_mem_to_reg,
   input  logic [REG_IDX_W-1:0] ex_reg_rd,
   output logic                 hazard
);

   logic rs1_hit;
   logic rs2_hit;

   assign rs1_hit = id_rs1_used && (id_rs1 == ex_reg_rd);
   assign rs2_hit = id_rs2_used && (id_rs2 == ex_reg_rd);
   assign hazard  = ex_mem_to_reg && (ex_reg_rd != '0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/ex_hazard_ctrl.sv
// ex_hazard_ctrl
//   EX-stage hazard controller: load-use bubbles, stalls while a branch,
//   call or return resolves its target, and a fixed-length flush of younger
//   instructions after every taken redirect.
//   Parameters : FLUSH_CYCLES (1..7) flush length, RET_MAX_WAIT (1..255)
//                longest wait for the return PC before ret_timeout.
//   Inputs     : clk, rst_n (async, active low), ID source fields, EX
//                load/control flags, pc_update_done, pc_src, ret_wb.
//   Outputs    : stall_if, stall_id, bubble_ex, flush_id, flush_ex,
//                ret_timeout (one-cycle pulse), state_dbg (FSM state).
//   Optional   : define EX_HAZARD_PERF_CNT_EN to add saturating 16-bit
//                stall_cnt (cycles with stall_if high) and flush_cnt
//                (number of FLUSH entries).
//
//   The block has no handshakes: every input is a level sampled each
//   cycle, and every output is a level valid in the cycle it is driven.
module ex_hazard_ctrl
   import ex_hazard_ctrl_pkg::*;
#(
   parameter int FLUSH_CYCLES = 2,
   parameter int RET_MAX_WAIT = 15
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [REG_IDX_W-1:0] id_rs1,
   input  logic [REG_IDX_W-1:0] id_rs2,
   input  logic                 id_rs1_used,
   input  logic                 id_rs2_used,
   input  logic                 ex_mem_to_reg,
   input  logic [REG_IDX_W-1:0] ex_reg_rd,
   input  logic                 ex_branch,
   input  logic                 ex_call,
   input  logic                 ex_ret_future,
   input  logic                 pc_update_done,
   input  logic                 pc_src,
   input  logic                 ret_wb,
   output logic                 stall_if,
   output logic                 stall_id,
   output logic                 bubble_ex,
   output logic                 flush_id,
   output logic                 flush_ex,
   output logic                 ret_timeout,
   output logic [1:0]           state_dbg
`ifdef EX_HAZARD_PERF_CNT_EN
   ,
   output logic [15:0]          stall_cnt,
   output logic [15:0]          flush_cnt
`endif
);

   localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);
   // Last RET_WAIT cycle: the counter starts at 0 on entry, so the
   // RET_MAX_WAIT-th cycle in the state sees RET_MAX_WAIT-1.
   localparam logic [7:0] RET_LAST   = 8'(RET_MAX_WAIT - 1);

   hz_state_t  state_q, state_d;
   logic [7:0] wait_cnt_q, wait_cnt_d;
   logic [2:0] flush_left_q, flush_left_d;
   logic       ld_use;
   logic       stall_c, bubble_c, flush_c, timeout_c;

   ld_use_detect u_ld_use_detect (
      .id_rs1        (id_rs1),
      .id_rs2        (id_rs2),
      .id_rs1_used   (id_rs1_used),
      .id_rs2_used   (id_rs2_used),
      .ex_mem_to_reg (ex_mem_to_reg),
      .ex_reg_rd     (ex_reg_rd),
      .hazard        (ld_use)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         wait_cnt_q   <= '0;
         flush_left_q <= '0;
      end else begin
         state_q      <= state_d;
         wait_cnt_q   <= wait_cnt_d;
         flush_left_q <= flush_left_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      wait_cnt_d   = wait_cnt_q;
      flush_left_d = flush_left_q;
      stall_c      = 1'b0;
      bubble_c     = 1'b0;
      flush_c      = 1'b0;
      timeout_c    = 1'b0;
      case (state_q)
         IDLE: begin
            wait_cnt_d   = '0;
            flush_left_d = '0;
            // Control transfers win over a coincident load-use hazard;
            // the control instruction itself proceeds, younger ones wait.
            if (ex_branch || ex_call) begin
               state_d = CTRL_WAIT;
            end else if (ex_ret_future) begin
               state_d = RET_WAIT;
            end else if (ld_use) begin
               stall_c  = 1'b1;
               bubble_c = 1'b1;
            end
         end
         CTRL_WAIT: begin
            stall_c  = 1'b1;
            bubble_c = 1'b1;
            if (pc_update_done) begin
               if (pc_src) begin
                  state_d      = FLUSH;
                  flush_left_d = FLUSH_LOAD;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         RET_WAIT: begin
            stall_c  = 1'b1;
            bubble_c = 1'b1;
            if (ret_wb) begin
               state_d      = FLUSH;
               flush_left_d = FLUSH_LOAD;
               wait_cnt_d   = '0;
            end else if (wait_cnt_q == RET_LAST) begin
               timeout_c  = 1'b1;
               state_d    = IDLE;
               wait_cnt_d = '0;
            end else begin
               wait_cnt_d = wait_cnt_q + 8'd1;
            end
         end
         FLUSH: begin
            // Incoming control flags belong to squashed instructions.
            flush_c = 1'b1;
            if (flush_left_q <= 3'd1) begin
               state_d      = IDLE;
               flush_left_d = '0;
            end else begin
               flush_left_d = flush_left_q - 3'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Gate with rst_n so a live hazard on the inputs cannot leak out
   // while reset is held.
   assign stall_if    = rst_n & stall_c;
   assign stall_id    = rst_n & stall_c;
   assign bubble_ex   = rst_n & bubble_c;
   assign flush_id    = rst_n & flush_c;
   assign flush_ex    = rst_n & flush_c;
   assign ret_timeout = rst_n & timeout_c;
   assign state_dbg   = state_q;

`ifdef EX_HAZARD_PERF_CNT_EN
   logic flush_entry;
   assign flush_entry = (state_q != FLUSH) && (state_d == FLUSH);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (stall_if && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
         end
         if (flush_entry && (flush_cnt != 16'hFFFF)) begin
            flush_cnt <= flush_cnt + 16'd1;
         end
      end
   end
`endif

endmodule
